// File: rtl/windowed_register_file.sv
// windowed_register_file
// SPARC-style windowed register file: 8 globals plus NWINDOWS x 16 windowed
// registers, with the current window pointer (CWP), window invalid mask (WIM)
// and registered window overflow/underflow trap pulses.
// Optional feature: define WINFILE_BYPASS_EN to forward same-cycle write data
// to a read port whose decoded physical register matches the write target.
module windowed_register_file #(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 4,
  localparam int CW      = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic [4:0]          in_PA,
  input  logic [4:0]          in_PB,
  output logic [WIDTH-1:0]    out_PA,
  output logic [WIDTH-1:0]    out_PB,
  input  logic [4:0]          in_PC,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                wr_en,
  input  logic [1:0]          win_op,
  input  logic [CW-1:0]       cwp_in,
  input  logic                wim_we,
  input  logic [NWINDOWS-1:0] wim_in,
  output logic [CW-1:0]       cwp,
  output logic [NWINDOWS-1:0] wim,
  output logic                win_ovf,
  output logic                win_unf,
  output logic [2:0]          tt
);

  // Unified storage: index 0 stands for r0 (never written, never read),
  // 1..7 are the globals, 8.. are the circular windowed registers.
  localparam int NPHYS = NWINDOWS * 16;
  localparam int NREG  = 8 + NPHYS;
  localparam int IW    = $clog2(NREG);

  localparam logic [1:0] OP_SAVE    = 2'b01;
  localparam logic [1:0] OP_RESTORE = 2'b10;
  localparam logic [1:0] OP_WRCWP   = 2'b11;
  localparam logic [2:0] TT_OVF     = 3'b101;
  localparam logic [2:0] TT_UNF     = 3'b110;

  logic [WIDTH-1:0]    r_regs [NREG];
  logic [CW-1:0]       r_cwp;
  logic [NWINDOWS-1:0] r_wim;
  logic                r_ovf;
  logic                r_unf;
  logic [2:0]          r_tt;

  logic [IW-1:0] w_pa_idx;
  logic [IW-1:0] w_pb_idx;
  logic [IW-1:0] w_wr_idx;
  logic [CW-1:0] w_save_tgt;
  logic [CW-1:0] w_rest_tgt;
  logic [CW-1:0] w_cwp_wr;

  // Architectural register -> unified storage index for a given window.
  // The ins of window c land on the outs of window c+1 because the windowed
  // region is a ring of 16-register steps with a 24-register view.
  function automatic logic [IW-1:0] f_decode(input logic [4:0] addr,
                                             input logic [CW-1:0] win);
    int idx;
    if (addr < 5'd8) begin
      idx = int'(addr);
    end else begin
      idx = int'(win) * 16 + int'(addr) - 8;
      if (idx >= NPHYS) idx = idx - NPHYS;
      idx = idx + 8;
    end
    return IW'(idx);
  endfunction

  // WRCWP values outside 0..NWINDOWS-1 wrap back into range.
  function automatic logic [CW-1:0] f_cwp_mod(input logic [CW-1:0] val);
    return CW'(int'(val) % NWINDOWS);
  endfunction

  assign w_pa_idx   = f_decode(in_PA, r_cwp);
  assign w_pb_idx   = f_decode(in_PB, r_cwp);
  // Writes decode against the pre-op window even if a window op is concurrent.
  assign w_wr_idx   = f_decode(in_PC, r_cwp);
  assign w_save_tgt = (r_cwp == '0) ? CW'(NWINDOWS - 1) : r_cwp - CW'(1);
  assign w_rest_tgt = (r_cwp == CW'(NWINDOWS - 1)) ? '0 : r_cwp + CW'(1);
  assign w_cwp_wr   = f_cwp_mod(cwp_in);

  // Combinational read ports; r0 is hard-wired to zero.
  always_comb begin
    out_PA = (w_pa_idx == '0) ? '0 : r_regs[w_pa_idx];
    out_PB = (w_pb_idx == '0) ? '0 : r_regs[w_pb_idx];
`ifdef WINFILE_BYPASS_EN
    if (wr_en && (w_wr_idx != '0) && (w_wr_idx == w_pa_idx)) out_PA = wr_data;
    if (wr_en && (w_wr_idx != '0) && (w_wr_idx == w_pb_idx)) out_PB = wr_data;
`else
`endif
  end

  // Register array: cleared on reset, otherwise one write per cycle.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wr_en && (w_wr_idx != '0)) begin
      r_regs[w_wr_idx] <= wr_data;
    end
  end

  // Window control: CWP/WIM update and trap pulses; WIM checks use old WIM.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_cwp <= '0;
      r_wim <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_tt  <= 3'b000;
    end else begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      case (win_op)
        OP_SAVE: begin
          if (r_wim[w_save_tgt]) begin
            r_ovf <= 1'b1;
            r_tt  <= TT_OVF;
          end else begin
            r_cwp <= w_save_tgt;
          end
        end
        OP_RESTORE: begin
          if (r_wim[w_rest_tgt]) begin
            r_unf <= 1'b1;
            r_tt  <= TT_UNF;
          end else begin
            r_cwp <= w_rest_tgt;
          end
        end
        OP_WRCWP: r_cwp <= w_cwp_wr;
        default: ;
      endcase
      if (wim_we) r_wim <= wim_in;
    end
  end

  assign cwp     = r_cwp;
  assign wim     = r_wim;
  assign win_ovf = r_ovf;
  assign win_unf = r_unf;
  assign tt      = r_tt;

endmodule

// File: tb/tb_windowed_register_file.sv
// Testbench for windowed_register_file: directed scenarios followed by random
// traffic, checked through an expectation queue against a behavioural model.
module tb_windowed_register_file;
  localparam int W     = 32;
  localparam int NW    = 4;
  localparam int CW    = 2;
  localparam int NPHYS = NW * 16;

  logic          Clk = 1'b0;
  logic          Clr;
  logic [4:0]    in_PA, in_PB, in_PC;
  logic [W-1:0]  out_PA, out_PB, wr_data;
  logic          wr_en, wim_we;
  logic [1:0]    win_op;
  logic [CW-1:0] cwp_in, cwp;
  logic [NW-1:0] wim_in, wim;
  logic          win_ovf, win_unf;
  logic [2:0]    tt;

  windowed_register_file #(.WIDTH(W), .NWINDOWS(NW)) dut (
    .Clk(Clk), .Clr(Clr), .in_PA(in_PA), .in_PB(in_PB), .out_PA(out_PA),
    .out_PB(out_PB), .in_PC(in_PC), .wr_data(wr_data), .wr_en(wr_en),
    .win_op(win_op), .cwp_in(cwp_in), .wim_we(wim_we), .wim_in(wim_in),
    .cwp(cwp), .wim(wim), .win_ovf(win_ovf), .win_unf(win_unf), .tt(tt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit            chk;
    logic [W-1:0]  pa, pb;
    logic [CW-1:0] cwp;
    logic [NW-1:0] wim;
    logic          ovf, unf;
    logic [2:0]    tt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [W-1:0]  m_g [8];
  logic [W-1:0]  m_w [NPHYS];
  int            m_cwp;
  logic [NW-1:0] m_wim;
  logic          m_ovf, m_unf;
  logic [2:0]    m_tt;
  bit            m_valid = 0;

  // Location of an architectural register in the current window: -1 for r0,
  // 1..7 for globals, 100+n for windowed register n.
  function automatic int m_loc(int r);
    if (r == 0) return -1;
    if (r < 8) return r;
    return 100 + ((m_cwp * 16 + r - 8) % NPHYS);
  endfunction

  function automatic logic [W-1:0] m_read(int r);
    int l;
    l = m_loc(r);
    if (l < 0) return '0;
    if (l < 8) return m_g[l];
    return m_w[l - 100];
  endfunction

  function automatic logic [W-1:0] m_port(int r);
`ifdef WINFILE_BYPASS_EN
    if (wr_en && m_loc(r) >= 0 && m_loc(r) == m_loc(int'(in_PC))) return wr_data;
`endif
    return m_read(r);
  endfunction

  task automatic m_clock();
    int l, t;
    if (Clr) begin
      foreach (m_g[i]) m_g[i] = '0;
      foreach (m_w[i]) m_w[i] = '0;
      m_cwp = 0; m_wim = '0; m_ovf = 0; m_unf = 0; m_tt = 3'b000; m_valid = 1;
    end else begin
      if (wr_en) begin
        l = m_loc(int'(in_PC));
        if (l > 0 && l < 8) m_g[l] = wr_data;
        else if (l >= 100) m_w[l - 100] = wr_data;
      end
      m_ovf = 0; m_unf = 0;
      if (win_op == 2'b01) begin
        t = (m_cwp + NW - 1) % NW;
        if (m_wim[t]) begin m_ovf = 1; m_tt = 3'b101; end else m_cwp = t;
      end else if (win_op == 2'b10) begin
        t = (m_cwp + 1) % NW;
        if (m_wim[t]) begin m_unf = 1; m_tt = 3'b110; end else m_cwp = t;
      end else if (win_op == 2'b11) begin
        m_cwp = int'(cwp_in) % NW;
      end
      if (wim_we) m_wim = wim_in;
    end
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic step();
    exp_t e;
    e.chk = m_valid;
    e.pa  = m_port(int'(in_PA));
    e.pb  = m_port(int'(in_PB));
    e.cwp = CW'(m_cwp);
    e.wim = m_wim;
    e.ovf = m_ovf;
    e.unf = m_unf;
    e.tt  = m_tt;
    q.push_back(e);
    @(posedge Clk);
    m_clock();
    #1;
  endtask

  task automatic idle_drv();
    Clr = 0; in_PA = 0; in_PB = 0; in_PC = 0; wr_data = '0; wr_en = 0;
    win_op = 2'b00; cwp_in = '0; wim_we = 0; wim_in = '0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    idle_drv(); in_PA = a; in_PB = b; step();
  endtask

  task automatic wr(input logic [4:0] r, input logic [W-1:0] d, input logic [4:0] a);
    idle_drv(); in_PC = r; wr_data = d; wr_en = 1; in_PA = a; in_PB = r; step();
  endtask

  task automatic wop(input logic [1:0] op, input logic [CW-1:0] ci);
    idle_drv(); win_op = op; cwp_in = ci; step();
  endtask

  task automatic setwim(input logic [NW-1:0] v);
    idle_drv(); wim_we = 1; wim_in = v; step();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; compare against queued expectations.
  always @(negedge Clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        check("out_PA", 64'(out_PA), 64'(e.pa));
        check("out_PB", 64'(out_PB), 64'(e.pb));
        check("cwp", 64'(cwp), 64'(e.cwp));
        check("wim", 64'(wim), 64'(e.wim));
        check("win_ovf", 64'(win_ovf), 64'(e.ovf));
        check("win_unf", 64'(win_unf), 64'(e.unf));
        check("tt", 64'(tt), 64'(e.tt));
      end
    end
  end

  initial begin
    int budget;
    idle_drv();
    @(posedge Clk); #1;
    // Reset, then read every architectural register
    Clr = 1; step();
    for (int i = 0; i < 16; i++) rd(5'(2 * i), 5'(2 * i + 1));
    // Window aliasing: outs of window 1 are ins of window 0
    wop(2'b11, 2'd1);
    wr(5'd8, 32'hA5A5_0001, 5'd8);
    wop(2'b01, '0);
    rd(5'd24, 5'd8);
    wr(5'd0, 32'hFFFF_FFFF, 5'd0);
    rd(5'd0, 5'd24);
    // Overflow trap, then successful SAVEs with wrap
    setwim(4'b0001);
    wop(2'b11, 2'd1);
    wop(2'b01, '0);
    wop(2'b01, '0);
    rd(5'd1, 5'd2);
    setwim(4'b0000);
    wop(2'b01, '0);
    wop(2'b01, '0);
    rd(5'd24, 5'd31);
    // Underflow trap, then RESTORE wrap
    setwim(4'b0100);
    wop(2'b11, 2'd1);
    wop(2'b10, '0);
    rd(5'd3, 5'd4);
    setwim(4'b0000);
    wop(2'b11, 2'd3);
    wop(2'b10, '0);
    rd(5'd8, 5'd9);
    // Globals are window-independent
    wr(5'd3, 32'h1234_5678, 5'd3);
    wop(2'b11, 2'd2);
    rd(5'd3, 5'd8);
    // WRCWP with WIM set never traps; reset beats a trapping SAVE
    setwim(4'b0010);
    idle_drv(); Clr = 1; win_op = 2'b01; wr_en = 1; in_PC = 5'd9; wr_data = 32'h5555_AAAA; step();
    rd(5'd9, 5'd0);
    // Same-cycle read of the register being written
    wr(5'd17, 32'hDEAD_BEEF, 5'd17);
    rd(5'd17, 5'd17);
    // Write concurrent with SAVE decodes against old window; WIM write with op
    idle_drv(); in_PC = 5'd20; wr_data = 32'hCAFE_0020; wr_en = 1; win_op = 2'b01; step();
    rd(5'd20, 5'd4);
    wop(2'b10, '0);
    rd(5'd20, 5'd4);
    idle_drv(); win_op = 2'b01; wim_we = 1; wim_in = 4'b1111; step();
    wop(2'b01, '0);
    wop(2'b10, '0);
    rd(5'd0, 5'd0);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle_drv();
      Clr     = ($urandom_range(0, 99) == 0);
      in_PA   = 5'($urandom_range(0, 31));
      in_PB   = 5'($urandom_range(0, 31));
      in_PC   = ($urandom_range(0, 3) == 0) ? in_PA : 5'($urandom_range(0, 31));
      wr_data = $urandom;
      wr_en   = $urandom_range(0, 1) == 1;
      win_op  = 2'($urandom_range(0, 3));
      cwp_in  = 2'($urandom_range(0, 3));
      wim_we  = ($urandom_range(0, 5) == 0);
      wim_in  = ($urandom_range(0, 2) == 0) ? NW'(1 << $urandom_range(0, NW - 1)) : '0;
      step();
    end
    idle_drv();
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge Clk);
      budget--;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
